// File: rtl/instr_encoder.sv
// Instruction encoder / program loader.
// Turns symbolic instruction requests into 32-bit MIPS words. The words are
// queued in a small FIFO and written to instruction memory at sequential
// word addresses.
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [ADDR_W:0]   words_written,
    output logic              err_illegal,
    output logic              busy
);

    localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    // words_written stops at 2^ADDR_W (one write per address)
    localparam logic [ADDR_W:0]   SAT_C   = {1'b1, {ADDR_W{1'b0}}};

    // Symbolic request kinds
    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_SLT  = 4'd4;
    localparam logic [3:0] K_ADDI = 4'd5;
    localparam logic [3:0] K_LW   = 4'd6;
    localparam logic [3:0] K_SW   = 4'd7;
    localparam logic [3:0] K_BEQ  = 4'd8;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } fifo_state_e;

    fifo_state_e       state_q, state_d;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   words_q;
    logic              err_q;

    logic [31:0]       enc_word;
    logic              kind_legal;
    logic              accept;
    logic              push;
    logic              pop;

    // Encode the request currently presented on the input port
    always_comb begin
        enc_word   = 32'h0;
        kind_legal = 1'b1;
        case (in_kind)
            K_ADD:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            K_SUB:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            K_AND:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            K_OR:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            K_SLT:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            K_ADDI:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
            K_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            K_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            K_BEQ:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
            default: kind_legal = 1'b0;
        endcase
    end

    // Handshake qualification and next occupancy / state
    always_comb begin
        // Full blocks a push even when a pop happens in the same cycle
        in_ready = (state_q != ST_FULL) && !flush;
        accept   = in_valid && in_ready;
        push     = accept && kind_legal;
        pop      = (state_q != ST_EMPTY) && mem_ready && !flush;
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == DEPTH_C) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_ACTIVE;
        end
    end

    // FIFO storage; contents are only observed through the occupancy gate
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= enc_word;
        end
    end

    // FIFO state machine, write address, completion count and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_C;
            words_q  <= '0;
            err_q    <= 1'b0;
        end else if (flush) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_C;
            words_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                addr_q   <= addr_q + ADDR_W'(1);
                if (words_q != SAT_C) begin
                    words_q <= words_q + (ADDR_W + 1)'(1);
                end
            end
            if (accept && !kind_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_valid     = (state_q != ST_EMPTY);
    assign busy          = (state_q != ST_EMPTY);
    assign mem_addr      = addr_q;
    assign mem_data      = (state_q != ST_EMPTY) ? fifo_mem[rd_ptr_q] : 32'h0;
    assign words_written = words_q;
    assign err_illegal   = err_q;

endmodule
